// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-port word RAM responder with programmable wait states
//
// Purpose: memory end of the CPU load/store port. One request is accepted at a
// time on the req channel; after WAIT_CYCLES extra cycles the result is
// presented on the rsp channel and held until the CPU takes it.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid / req_ready    request handshake
//   req_we, req_addr         store/load select, byte address
//   req_wdata, req_wstrb     store data and byte-lane enables
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata, rsp_err       load data (0 for stores/faults), fault flag
//
// Optional feature: define DMEM_ERR_EN to flag misaligned or out-of-range
// accesses through rsp_err; otherwise addresses wrap modulo the RAM depth.

module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic [3:0] cnt;

    logic [31:0] mem [0:DEPTH-1];

    // Request captured at accept
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_idx;
    logic [31:0]           lat_wdata;
    logic [3:0]            lat_wstrb;
    logic                  lat_fault;

    logic                  req_fault;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  hs;
    logic                  commit;

    logic                  src_we;
    logic [ADDR_WIDTH-1:0] src_idx;
    logic [31:0]           src_wdata;
    logic [3:0]            src_wstrb;
    logic                  src_fault;

    logic                  err_q;

    assign req_idx = req_addr[ADDR_WIDTH+1:2];

`ifdef DMEM_ERR_EN
    assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_WIDTH+2] != '0);
`else
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};
    assign req_fault   = 1'b0;
`endif

    // Held low throughout reset, not just after it
    assign req_ready = (state == IDLE) && rst;
    assign rsp_valid = (state == RESP);
    assign rsp_err   = err_q;
    assign hs        = req_valid && req_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (hs) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (cnt == 4'd0) state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RAM access happens on the edge entering RESP. With WAIT_CYCLES=0 that is
    // the accept edge itself, so the request must come straight from the inputs.
    assign commit    = (state != RESP) && (state_next == RESP);
    assign src_we    = (state == IDLE) ? req_we    : lat_we;
    assign src_idx   = (state == IDLE) ? req_idx   : lat_idx;
    assign src_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign src_wstrb = (state == IDLE) ? req_wstrb : lat_wstrb;
    assign src_fault = (state == IDLE) ? req_fault : lat_fault;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_wstrb <= 4'd0;
            lat_fault <= 1'b0;
            rsp_rdata <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            if (hs) begin
                cnt       <= CNT_INIT;
                lat_we    <= req_we;
                lat_idx   <= req_idx;
                lat_wdata <= req_wdata;
                lat_wstrb <= req_wstrb;
                lat_fault <= req_fault;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rsp_rdata <= (src_we || src_fault) ? 32'd0 : mem[src_idx];
                err_q     <= src_fault;
            end else if (state == RESP && rsp_ready) begin
                rsp_rdata <= 32'd0;
                err_q     <= 1'b0;
            end
        end
    end

    // RAM contents are not reset; commit is only reachable out of reset
    always_ff @(posedge clk) begin
        if (commit && src_we && !src_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (src_wstrb[i]) mem[src_idx][8*i +: 8] <= src_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder

module tb_data_mem_responder;

    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_wstrb;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd;
    logic        er;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wstrb(z_req_wstrb),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction on the WAIT_CYCLES=2 instance; hold = cycles of
    // response backpressure after rsp_valid rises.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int hold,
                       output logic [31:0] rdata, output logic err);
        int n;
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wdata; req_wstrb = wstrb; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        // Scramble request inputs; the responder must ignore them now
        req_valid = 1'b0; req_we = ~we; req_addr = 32'h30;
        req_wdata = $urandom; req_wstrb = 4'hF;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        // Responder enters RESP WAIT_CYCLES edges after the accept edge
        check("latency", 32'(lat), 32'(WAIT_CYCLES));
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rdata", rsp_rdata, rdata);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_consumed", {31'd0, rsp_valid}, 32'd0);
        check("ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    // Back-to-back accesses on the WAIT_CYCLES=0 instance, rsp_ready held high
    task automatic z_burst(input logic we);
        int iss[8];
        int rsp[8];
        int issued;
        int rcvd;
        issued = 0;
        rcvd   = 0;
        z_rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
            @(negedge clk);
            if (z_rsp_valid) begin
                rsp[rcvd] = cyc;
                if (we) check("z_store_rdata", z_rsp_rdata, 32'd0);
                else    check("z_load_rdata", z_rsp_rdata, 32'hA000_0000 + 32'(rcvd) * 32'h111);
                check("z_err", {31'd0, z_rsp_err}, 32'd0);
                rcvd++;
            end
            if (z_req_ready && issued < 8) begin
                z_req_valid = 1'b1; z_req_we = we;
                z_req_addr  = 32'h40 + 32'(issued) * 32'd4;
                z_req_wdata = 32'hA000_0000 + 32'(issued) * 32'h111;
                z_req_wstrb = 4'hF;
                iss[issued] = cyc;
                issued++;
            end else begin
                z_req_valid = 1'b0;
            end
        end
        z_req_valid = 1'b0;
        check("z_count", 32'(rcvd), 32'd8);
        for (int k = 0; k < rcvd; k++) begin
            check("z_latency", 32'(rsp[k] - iss[k]), 32'd1);
            if (k > 0) check("z_spacing", 32'(rsp[k] - rsp[k-1]), 32'd2);
        end
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0;
        rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0;
        z_req_wstrb = 4'd0; z_rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // Full-word store then load
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
        check("store_rdata", rd, 32'd0);
        check("store_err", {31'd0, er}, 32'd0);
        txn(1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er);
        check("load_10", rd, 32'hDEAD_BEEF);
        check("load_10_err", {31'd0, er}, 32'd0);

        // Byte-lane merge, load under 5 cycles of backpressure
        txn(1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, rd, er);
        txn(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0, rd, er);
        txn(1'b0, 32'h20, 32'd0, 4'h0, 5, rd, er);
        check("merge_20", rd, 32'h11BB_33DD);

        // wstrb=0000 store is a no-op with a normal response
        txn(1'b1, 32'h10, 32'h0000_0000, 4'h0, 0, rd, er);
        check("nostrb_err", {31'd0, er}, 32'd0);
        txn(1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er);
        check("nostrb_keep", rd, 32'hDEAD_BEEF);

`ifdef DMEM_ERR_EN
        txn(1'b1, 32'h13, 32'h0, 4'hF, 0, rd, er);
        check("misalign_err", {31'd0, er}, 32'd1);
        check("misalign_rdata", rd, 32'd0);
        txn(1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er);
        check("misalign_nowrite", rd, 32'hDEAD_BEEF);
        txn(1'b0, 32'h1000, 32'd0, 4'h0, 0, rd, er);
        check("range_err", {31'd0, er}, 32'd1);
        check("range_rdata", rd, 32'd0);
`else
        txn(1'b0, 32'h1010, 32'd0, 4'h0, 0, rd, er);
        check("wrap_1010", rd, 32'hDEAD_BEEF);
        check("wrap_err", {31'd0, er}, 32'd0);
        txn(1'b0, 32'h13, 32'd0, 4'h0, 0, rd, er);
        check("lowbits_ignored", rd, 32'hDEAD_BEEF);
`endif

        // Zero-wait instance: back-to-back stores then loads
        z_burst(1'b1);
        z_burst(1'b0);

        // Reset during WAIT of a store drops it
        txn(1'b1, 32'h30, 32'h0, 4'hF, 0, rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30;
        req_wdata = 32'h5555_5555; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready", {31'd0, req_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("after_rst_valid", {31'd0, rsp_valid}, 32'd0);
        end
        txn(1'b0, 32'h30, 32'd0, 4'h0, 0, rd, er);
        check("dropped_store", rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
